glb_block_arb: RTL and testbench
================================

GLB_BLOCK_ARB -- requirements
Module: glb_block_arb

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, meaning number of upstream block producers (2..8).
REQ-002 The block SHALL have parameter NUM_BLOCKS, default 1, meaning blocks each requester sends before it is finished.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, NUM_REQ x 16 bits, meaning per-requester stream word.
REQ-006 The block SHALL have port in_valid, input, NUM_REQ bits, meaning per-requester word valid.
REQ-007 The block SHALL have port in_ready, output, NUM_REQ bits, meaning per-requester word accepted.
REQ-008 The block SHALL have port out_data, output, 16 bits, meaning word to the GLB read sink.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning out_data valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning sink accepts word.
REQ-011 The block SHALL have port grant_id, output, 3 bits, meaning index of the requester owning the output.
REQ-012 The block SHALL have port done, output, 1 bit, meaning all requesters finished.

Function
REQ-013 A block SHALL be one header word (payload length L, unsigned 16-bit) followed by L payload words; a transfer is valid&&ready on the same cycle.
REQ-014 FSM states SHALL be IDLE, HDR, BODY, DONE.
REQ-015 IDLE: the lowest-index eligible requester (in_valid high, not finished) at or after rr_ptr, wrapping modulo NUM_REQ, SHALL be granted; grant_id is registered, and the FSM moves to HDR next cycle.
REQ-016 In HDR/BODY: out_valid=in_valid[grant_id], out_data=in_data[grant_id], in_ready[grant_id]=out_ready, all other in_ready low, zero added latency.
REQ-017 HDR: on header transfer, L SHALL be loaded into a 16-bit down-counter; L=0 ends the block immediately; otherwise go to BODY.
REQ-018 BODY: each transfer decrements the counter; the transfer at count 1 ends the block.
REQ-019 Block end: the requester's block count increments, rr_ptr=(grant_id+1) mod NUM_REQ, and the FSM returns to IDLE; a grant is never preempted mid-block.
REQ-020 A requester with NUM_BLOCKS blocks complete SHALL be finished and never granted again.
REQ-021 When all requesters are finished the FSM SHALL enter DONE: done=1 sticky, out_valid=0, all in_ready=0, until reset.
REQ-022 In IDLE and DONE, out_valid and all in_ready SHALL be 0.
REQ-023 out_valid held with out_ready low SHALL keep out_data stable when the granted requester holds its data.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, rr_ptr=0, grant_id=0, counter=0, block counts=0, done=0, out_valid=0, in_ready=0.
REQ-025 Reset mid-block SHALL abandon the partial block without a count increment; after release, arbitration restarts from requester 0.

Configuration
REQ-026 With GLB_BLOCK_ARB_OUT_REG_EN defined, out_data/out_valid SHALL come from a 2-entry skid register: latency 1 cycle, full throughput, in_ready[grant_id] = skid not full (no combinational out_ready path), block end counted on input-side transfer, and DONE entered only after the skid drains.
REQ-027 Without the macro, the path SHALL be combinational per REQ-016.

Structure
REQ-028 Package glb_block_arb_pkg SHALL hold the FSM state enum, GLB_WORD_W=16, and GLB_MAX_REQ=8.
REQ-029 Sub-module glb_arb_skid SHALL implement the 2-entry register slice, instantiated only under GLB_BLOCK_ARB_OUT_REG_EN.

Verification
REQ-030 NUM_REQ=2, req0 sends {3,A,B,C}, req1 idle, out_ready=1 -> out sequence 3,A,B,C with grant_id=0, then req0 finished.
REQ-031 Both requesters valid from reset, each sends {2,x,y}, NUM_BLOCKS=1 -> req0 block fully then req1 block, no interleave, done=1 after the last word.
REQ-032 NUM_BLOCKS=2, both always valid -> grant order 0,1,0,1; done after the fourth block.
REQ-033 Header L=0 from req1 -> a single output word 0, then immediate return to IDLE and rr_ptr advance.
REQ-034 out_ready toggles 1,0,1,0 during BODY -> no lost or duplicated words, out_data stable while stalled.
REQ-035 rst_n pulsed low after 2 of 5 payload words -> outputs clear immediately; a fresh block from req1 after release is forwarded starting with its header.

Source files
------------

// File: rtl/glb_block_arb_pkg.sv
// Shared types and constants for the GLB block arbiter.
package glb_block_arb_pkg;

    localparam int GLB_WORD_W  = 16;
    localparam int GLB_MAX_REQ = 8;

    // Arbiter control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    // Returns (base + off) wrapped into 0..n-1; base < n and off < n are assumed.
    function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off, input int n);
        int sum;
        sum = int'(base) + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return 3'(sum);
    endfunction

endpackage

// File: rtl/glb_arb_skid.sv
// Two-entry register slice: one cycle latency, full throughput, and an
// input-side ready that never depends combinationally on out_ready.
module glb_arb_skid #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign empty     = (count == 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/glb_block_arb.sv
// Round-robin block arbiter: grants one upstream producer at a time for a
// whole block (header word L followed by L payload words) and retires each
// producer after NUM_BLOCKS blocks. Define GLB_BLOCK_ARB_OUT_REG_EN to put a
// two-entry register slice on the output path; otherwise the granted
// requester is forwarded combinationally.
//
// Handshake: a word moves on any interface only in a cycle where valid and
// ready are both high at the rising clock edge; valid never waits for ready.
module glb_block_arb
    import glb_block_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_BLOCKS = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0][GLB_WORD_W-1:0]  in_data,
    input  logic [NUM_REQ-1:0]                  in_valid,
    output logic [NUM_REQ-1:0]                  in_ready,
    output logic [GLB_WORD_W-1:0]               out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2:0]                          grant_id,
    output logic                                done,
    output arb_state_t                          fsm_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_BLOCKS + 1);

    arb_state_t                state;
    arb_state_t                state_nxt;
    logic [2:0]                rr_ptr;
    logic [2:0]                rr_ptr_nxt;
    logic [2:0]                grant_nxt;
    logic [GLB_WORD_W-1:0]     len_cnt;
    logic [GLB_WORD_W-1:0]     len_cnt_nxt;
    logic [CNT_W-1:0]          blk_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]        finished;
    logic [NUM_REQ-1:0]        eligible;
    logic [2*NUM_REQ-1:0]      elig_rot;
    logic                      all_finished;
    logic                      pick_found;
    logic [2:0]                pick_id;
    logic [IDX_W-1:0]          gidx;
    logic                      active;
    logic                      src_valid;
    logic [GLB_WORD_W-1:0]     src_data;
    logic                      src_ready;
    logic                      xfer;
    logic                      blk_end;
    logic                      drained;

    assign gidx      = grant_id[IDX_W-1:0];
    assign active    = (state == ST_HDR) || (state == ST_BODY);
    assign src_valid = in_valid[gidx];
    assign src_data  = in_data[gidx];
    assign xfer      = active && src_valid && src_ready;
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    // A requester is retired once it has completed all of its blocks.
    always_comb begin
        finished = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            finished[i] = (blk_cnt[i] == CNT_W'(NUM_BLOCKS));
        end
    end

    assign eligible     = in_valid & ~finished;
    assign all_finished = &finished;
    // Rotate so bit 0 is the requester at rr_ptr.
    assign elig_rot     = {eligible, eligible} >> rr_ptr;

    // First eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig_rot[i]) begin
                pick_found = 1'b1;
                pick_id    = wrap_idx(rr_ptr, i, NUM_REQ);
            end
        end
    end

    // Next-state logic: grant in IDLE, header/body length tracking, block end.
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        rr_ptr_nxt  = rr_ptr;
        len_cnt_nxt = len_cnt;
        blk_end     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (all_finished && drained) begin
                    state_nxt = ST_DONE;
                end else if (pick_found) begin
                    grant_nxt = pick_id;
                    state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if (src_data == '0) begin
                        blk_end = 1'b1;
                    end else begin
                        len_cnt_nxt = src_data;
                        state_nxt   = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (xfer) begin
                    len_cnt_nxt = len_cnt - 16'd1;
                    if (len_cnt == 16'd1) begin
                        blk_end = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (blk_end) begin
            state_nxt  = ST_IDLE;
            rr_ptr_nxt = wrap_idx(grant_id, 1, NUM_REQ);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            len_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            len_cnt  <= len_cnt_nxt;
        end
    end

    // Per-requester completed-block counters; a reset drops a partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                blk_cnt[i] <= '0;
            end
        end else if (blk_end) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gidx == IDX_W'(i)) begin
                    blk_cnt[i] <= blk_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef GLB_BLOCK_ARB_OUT_REG_EN
    logic skid_in_ready;
    logic skid_empty;

    glb_arb_skid #(
        .W(GLB_WORD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (src_data),
        .in_valid  (active && src_valid),
        .in_ready  (skid_in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .empty     (skid_empty)
    );

    assign drained = skid_empty;

    // Granted requester is ready whenever the slice has room.
    always_comb begin
        in_ready  = '0;
        src_ready = active && skid_in_ready;
        if (active) begin
            in_ready[gidx] = skid_in_ready;
        end
    end
`else
    assign drained = 1'b1;

    // Combinational pass-through of the granted requester.
    always_comb begin
        in_ready  = '0;
        src_ready = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        if (active) begin
            src_ready      = out_ready;
            in_ready[gidx] = out_ready;
            out_valid      = src_valid;
            out_data       = src_data;
        end
    end
`endif

endmodule

// File: tb/tb_glb_block_arb.sv
// Testbench for glb_block_arb with NUM_REQ=2, NUM_BLOCKS=2.
module tb_glb_block_arb;
    import glb_block_arb_pkg::*;

    localparam int NUM_REQ    = 2;
    localparam int NUM_BLOCKS = 2;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0][15:0]   in_data;
    logic [NUM_REQ-1:0]         in_valid;
    logic [NUM_REQ-1:0]         in_ready;
    logic [15:0]                out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [2:0]                 grant_id;
    logic                       done;
    arb_state_t                 fsm_state;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ready_mode = 0;

    logic [15:0] src0_q[$];
    logic [15:0] src1_q[$];
    logic [15:0] exp_q[$];
    logic [2:0]  exp_gid_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    glb_block_arb #(
        .NUM_REQ   (NUM_REQ),
        .NUM_BLOCKS(NUM_BLOCKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .grant_id  (grant_id),
        .done      (done),
        .fsm_state (fsm_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // One cycle: drive at negedge, sample shortly after, account for the
    // transfers that the next rising edge will perform.
    task automatic step();
        @(negedge clk);
        in_valid[0] = (src0_q.size() > 0);
        in_data[0]  = (src0_q.size() > 0) ? src0_q[0] : 16'h0;
        in_valid[1] = (src1_q.size() > 0);
        in_data[1]  = (src1_q.size() > 0) ? src1_q[0] : 16'h0;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
        #1;
        if (prev_stall && out_valid) begin
            check("stall_hold", 32'(out_data), 32'(prev_data));
        end
        check("ready_onehot", 32'($countones(in_ready) > 1), 32'(0));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_word", 32'(out_valid && out_ready), 32'(0));
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                check("grant_id", 32'(grant_id), 32'(exp_gid_q.pop_front()));
                check("done_early", 32'(done), 32'(0));
            end
        end
        if (in_valid[0] && in_ready[0]) void'(src0_q.pop_front());
        if (in_valid[1] && in_ready[1]) void'(src1_q.pop_front());
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
        check({tag, "_grant_id"}, 32'(grant_id), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        exp_gid_q.delete();
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;
    endtask

    task automatic push_word(input int r, input logic [15:0] w);
        if (r == 0) src0_q.push_back(w);
        else        src1_q.push_back(w);
    endtask

    task automatic expect_word(input logic [15:0] w, input logic [2:0] g);
        exp_q.push_back(w);
        exp_gid_q.push_back(g);
    endtask

    // Reference: whole blocks, strict round robin over requesters with data
    // left, starting at requester 0. All sources are valid from the start.
    task automatic build_expected();
        logic [15:0] m0[$];
        logic [15:0] m1[$];
        int ptr;
        int r;
        int len;
        m0  = src0_q;
        m1  = src1_q;
        ptr = 0;
        while (m0.size() > 0 || m1.size() > 0) begin
            r = ptr;
            if ((r == 0 && m0.size() == 0) || (r == 1 && m1.size() == 0)) r = 1 - r;
            len = (r == 0) ? int'(m0[0]) : int'(m1[0]);
            for (int k = 0; k <= len; k++) begin
                if (r == 0) expect_word(m0.pop_front(), 3'd0);
                else        expect_word(m1.pop_front(), 3'd1);
            end
            ptr = 1 - r;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check("done_set", 32'(done), 32'(1));
    endtask

    task automatic random_run(input int mode);
        int len;
        do_reset();
        ready_mode = mode;
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                len = $urandom_range(0, 5);
                push_word(r, 16'(len));
                for (int k = 0; k < len; k++) push_word(r, 16'($urandom));
            end
        end
        build_expected();
        drain(600);
        wait_done(20);
        // Finished: extra offered words must be ignored.
        push_word(0, 16'h0001);
        push_word(0, 16'h1234);
        push_word(1, 16'h0000);
        repeat (5) step();
        check("done_gate_ready", 32'(in_ready), 32'(0));
        check("done_gate_valid", 32'(out_valid), 32'(0));
        check("done_sticky", 32'(done), 32'(1));
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Single active requester, header 3 then 3 payload words.
        do_reset();
        ready_mode = 0;
        push_word(0, 16'd3); push_word(0, 16'hA0A0); push_word(0, 16'hB1B1); push_word(0, 16'hC2C2);
        expect_word(16'd3, 3'd0); expect_word(16'hA0A0, 3'd0);
        expect_word(16'hB1B1, 3'd0); expect_word(16'hC2C2, 3'd0);
        drain(40);
        // Second block with L=0 retires requester 0.
        push_word(0, 16'd0);
        expect_word(16'd0, 3'd0);
        drain(20);
        push_word(0, 16'd1); push_word(0, 16'h0055);
        for (int i = 0; i < 8; i++) begin
            step();
            check("retired_ready", 32'(in_ready[0]), 32'(0));
        end
        check("retired_words_left", 32'(src0_q.size()), 32'(2));
        check("not_done", 32'(done), 32'(0));

        // Zero-length headers on both sides; round robin must still alternate.
        do_reset();
        ready_mode = 0;
        push_word(0, 16'd2); push_word(0, 16'h0011); push_word(0, 16'h0022); push_word(0, 16'd0);
        push_word(1, 16'd0); push_word(1, 16'd1); push_word(1, 16'h0033);
        build_expected();
        drain(60);
        wait_done(20);

        // Randomised runs under steady, toggling and random backpressure.
        for (int run = 0; run < 6; run++) begin
            random_run(run % 3);
        end

        // Reset in the middle of a block.
        do_reset();
        ready_mode = 0;
        push_word(0, 16'd5);
        for (int k = 1; k <= 5; k++) push_word(0, 16'(k));
        expect_word(16'd5, 3'd0); expect_word(16'd1, 3'd0); expect_word(16'd2, 3'd0);
        drain(40);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_grant", 32'(grant_id), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        src0_q.delete();
        exp_q.delete();
        exp_gid_q.delete();
        in_valid   = '0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_word(1, 16'd2); push_word(1, 16'h00A1); push_word(1, 16'h00A2);
        expect_word(16'd2, 3'd1); expect_word(16'h00A1, 3'd1); expect_word(16'h00A2, 3'd1);
        drain(40);
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
